// File: rtl/crypto_alu.sv
// crypto_alu: 32-bit execute-stage ALU with integer, logic, rotate/shift and
// byte-granular cipher primitives (byte select/insert, shift-in, AES S-box).
// The result is registered with one cycle of latency and a synchronous reset.
module crypto_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  index,
  input  logic [3:0]  ALUcontrol,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [31:0] SrcC,
  input  logic [1:0]  column,
  input  logic [7:0]  lastData,
  output logic [31:0] ALUresult
);

  localparam logic [3:0] OpAdd     = 4'b0000;
  localparam logic [3:0] OpByteSel = 4'b0001;
  localparam logic [3:0] OpRotl    = 4'b0010;
  localparam logic [3:0] OpXor3    = 4'b0011;
  localparam logic [3:0] OpShiftIn = 4'b0100;
  localparam logic [3:0] OpSbox    = 4'b0101;
  localparam logic [3:0] OpByteIns = 4'b0110;
  localparam logic [3:0] OpSub     = 4'b0111;
  localparam logic [3:0] OpAnd     = 4'b1000;
  localparam logic [3:0] OpOr      = 4'b1001;
  localparam logic [3:0] OpXor     = 4'b1010;
  localparam logic [3:0] OpShl     = 4'b1011;
  localparam logic [3:0] OpShr     = 4'b1100;

  // AES forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] pos;
    // Entry b sits (255 - b) bytes above bit 0.
    pos = {~b, 3'b000};
    return SboxTable[pos +: 8];
  endfunction

  logic [31:0] result_d, result_q;
  logic [63:0] rot_wide;
  logic [31:0] ins_word;

  // Rotate via a doubled operand: the upper half holds A rotated left.
  assign rot_wide = {SrcA, SrcA} << SrcB[4:0];

  // Byte insert: A with the selected lane overwritten by lastData.
  always_comb begin
    ins_word = SrcA;
    ins_word[{column, 3'b000} +: 8] = lastData;
  end

  // Next-result decode from the current operation and operands.
  always_comb begin
    result_d = 32'h0000_0000;
    case (ALUcontrol)
      OpAdd:     result_d = SrcA + SrcB;
      OpByteSel: result_d = {24'h00_0000, SrcA[{index, 3'b000} +: 8]};
      OpRotl:    result_d = rot_wide[63:32];
      OpXor3:    result_d = SrcA ^ SrcB ^ SrcC;
      OpShiftIn: result_d = {SrcA[23:0], lastData};
      OpSbox:    result_d = {sbox(SrcA[31:24]), sbox(SrcA[23:16]),
                             sbox(SrcA[15:8]), sbox(SrcA[7:0])};
      OpByteIns: result_d = ins_word;
      OpSub:     result_d = SrcA - SrcB;
      OpAnd:     result_d = SrcA & SrcB;
      OpOr:      result_d = SrcA | SrcB;
      OpXor:     result_d = SrcA ^ SrcB;
      OpShl:     result_d = SrcA << SrcB[4:0];
      OpShr:     result_d = SrcA >> SrcB[4:0];
      default:   result_d = 32'h0000_0000;
    endcase
  end

  // Result register; reset overrides whatever op is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= 32'h0000_0000;
    end else begin
      result_q <= result_d;
    end
  end

  assign ALUresult = result_q;

endmodule

// File: tb/tb_crypto_alu.sv
// Self-checking bench for crypto_alu: reset sequences, a directed vector
// table, an exhaustive S-box sweep and randomized ops against a model.
module tb_crypto_alu;

  logic        clk;
  logic        reset;
  logic [1:0]  index;
  logic [3:0]  ALUcontrol;
  logic [31:0] SrcA, SrcB, SrcC;
  logic [1:0]  column;
  logic [7:0]  lastData;
  logic [31:0] ALUresult;

  int unsigned n_total;
  int unsigned n_pass;

  logic [7:0] sbox_ref [256];

  crypto_alu dut (
    .clk        (clk),
    .reset      (reset),
    .index      (index),
    .ALUcontrol (ALUcontrol),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .SrcC       (SrcC),
    .column     (column),
    .lastData   (lastData),
    .ALUresult  (ALUresult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [1:0]  idx;
    logic [1:0]  col;
    logic [7:0]  ld;
    logic [31:0] exp;
  } vec_t;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] a;
    p = 8'h00;
    a = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    return (v << s) | (v >> (8 - s));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                    ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c,
                                        input logic [1:0] idx, input logic [1:0] col,
                                        input logic [7:0] ld);
    int s;
    int li;
    int lc;
    s  = int'(b % 32);
    li = 8 * int'(idx);
    lc = 8 * int'(col);
    case (op)
      4'd0:  return a + b;
      4'd1:  return (a >> li) & 32'hFF;
      4'd2:  return (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      4'd3:  return a ^ b ^ c;
      4'd4:  return (a * 256) | {24'h0, ld};
      4'd5:  return {sbox_ref[a[31:24]], sbox_ref[a[23:16]], sbox_ref[a[15:8]],
                     sbox_ref[a[7:0]]};
      4'd6:  return (a & ~(32'hFF << lc)) | ({24'h0, ld} << lc);
      4'd7:  return a + (~b + 32'd1);
      4'd8:  return a & b;
      4'd9:  return a | b;
      4'd10: return a ^ b;
      4'd11: return a << s;
      4'd12: return a >> s;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [1:0] idx, input logic [1:0] col,
                       input logic [7:0] ld);
    ALUcontrol = op;
    SrcA = a;
    SrcB = b;
    SrcC = c;
    index = idx;
    column = col;
    lastData = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[20];

  function automatic vec_t mk(input string name, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] c,
                              input logic [1:0] idx, input logic [1:0] col,
                              input logic [7:0] ld, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.c = c;
    v.idx = idx; v.col = col; v.ld = ld; v.exp = exp;
    return v;
  endfunction

  initial begin
    logic [31:0] a, b, c, exp;
    logic [3:0]  op;
    logic [1:0]  idx, col;
    logic [7:0]  ld;
    n_total = 0;
    n_pass  = 0;
    build_sbox();

    tbl[0]  = mk("add",         4'h0, 32'd8, 32'd5, 32'h0, 2'd0, 2'd0, 8'h00, 32'h0000000D);
    tbl[1]  = mk("sub",         4'h7, 32'd10, 32'd3, 32'h0, 2'd0, 2'd0, 8'h00, 32'h00000007);
    tbl[2]  = mk("sub_wrap",    4'h7, 32'd3, 32'd10, 32'h0, 2'd0, 2'd0, 8'h00, 32'hFFFFFFF9);
    tbl[3]  = mk("xor3",        4'h3, 32'd10, 32'd3, 32'h25423513, 2'd0, 2'd0, 8'h00,
                 32'h2542351A);
    tbl[4]  = mk("rotl4",       4'h2, 32'h6649D86C, 32'd4, 32'h0, 2'd0, 2'd0, 8'h00,
                 32'h649D86C6);
    tbl[5]  = mk("rotl0",       4'h2, 32'h6649D86C, 32'd0, 32'h0, 2'd0, 2'd0, 8'h00,
                 32'h6649D86C);
    tbl[6]  = mk("rotl36",      4'h2, 32'h6649D86C, 32'd36, 32'h0, 2'd0, 2'd0, 8'h00,
                 32'h649D86C6);
    tbl[7]  = mk("bytesel3",    4'h1, 32'h1BC492BB, 32'h0, 32'h0, 2'd3, 2'd0, 8'h00,
                 32'h0000001B);
    tbl[8]  = mk("bytesel0",    4'h1, 32'h1BC492BB, 32'h0, 32'h0, 2'd0, 2'd0, 8'h00,
                 32'h000000BB);
    tbl[9]  = mk("shiftin",     4'h4, 32'h1BC492BB, 32'h0, 32'h0, 2'd0, 2'd0, 8'h7C,
                 32'hC492BB7C);
    tbl[10] = mk("byteins0",    4'h6, 32'h1BC492BB, 32'h0, 32'h0, 2'd0, 2'd0, 8'h7C,
                 32'h1BC4927C);
    tbl[11] = mk("byteins3",    4'h6, 32'h1BC492BB, 32'h0, 32'h0, 2'd0, 2'd3, 8'h7C,
                 32'h7CC492BB);
    tbl[12] = mk("sbox0123",    4'h5, 32'h00010203, 32'h0, 32'h0, 2'd0, 2'd0, 8'h00,
                 32'h637C777B);
    tbl[13] = mk("sboxff",      4'h5, 32'hFFFFFFFF, 32'h0, 32'h0, 2'd0, 2'd0, 8'h00,
                 32'h16161616);
    tbl[14] = mk("and",         4'h8, 32'hF0F0FF00, 32'h3C3C0FF0, 32'h0, 2'd0, 2'd0, 8'h00,
                 32'h30300F00);
    tbl[15] = mk("or",          4'h9, 32'hF0F0FF00, 32'h3C3C0FF0, 32'h0, 2'd0, 2'd0, 8'h00,
                 32'hFCFCFFF0);
    tbl[16] = mk("xor",         4'hA, 32'hF0F0FF00, 32'h3C3C0FF0, 32'h0, 2'd0, 2'd0, 8'h00,
                 32'hCCCCF0F0);
    tbl[17] = mk("shl",         4'hB, 32'h80000001, 32'hFFFFFFE4, 32'h0, 2'd0, 2'd0, 8'h00,
                 32'h00000010);
    tbl[18] = mk("shr",         4'hC, 32'h80000001, 32'd31, 32'h0, 2'd0, 2'd0, 8'h00,
                 32'h00000001);
    tbl[19] = mk("reserved",    4'hF, 32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 2'd3, 2'd3,
                 8'hFF, 32'h00000000);

    // Reset held two edges with a live op; output stays zero.
    reset = 1'b1;
    drive(4'h0, 32'd8, 32'd5, 32'h0, 2'd0, 2'd0, 8'h00);
    tick();
    check("reset_edge1", ALUresult, 32'h0);
    tick();
    check("reset_edge2", ALUresult, 32'h0);
    reset = 1'b0;
    tick();
    check("first_after_reset", ALUresult, 32'h0000000D);

    // Directed table, applied back-to-back one op per cycle.
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].idx, tbl[i].col, tbl[i].ld);
      tick();
      check(tbl[i].name, ALUresult, tbl[i].exp);
      check({tbl[i].name, "_model"}, ALUresult,
            model(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].idx, tbl[i].col,
                  tbl[i].ld));
    end

    // Output must not follow input changes before the next edge.
    drive(4'h0, 32'd100, 32'd1, 32'h0, 2'd0, 2'd0, 8'h00);
    tick();
    drive(4'h7, 32'd100, 32'd1, 32'h0, 2'd0, 2'd0, 8'h00);
    #3;
    check("hold_between_edges", ALUresult, 32'd101);
    tick();
    check("sub_after_hold", ALUresult, 32'd99);

    // Reset mid-stream discards the in-flight result.
    drive(4'h9, 32'h00FF0000, 32'h000000FF, 32'h0, 2'd0, 2'd0, 8'h00);
    reset = 1'b1;
    tick();
    check("midstream_reset", ALUresult, 32'h0);
    reset = 1'b0;
    drive(4'hA, 32'hAAAA5555, 32'hFFFF0000, 32'h0, 2'd0, 2'd0, 8'h00);
    tick();
    check("after_midstream", ALUresult, 32'h55555555);

    // Every S-box entry, four per word.
    for (int k = 0; k < 64; k++) begin
      a = {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)};
      drive(4'h5, a, $urandom, $urandom, 2'($urandom), 2'($urandom), 8'($urandom));
      tick();
      check("sbox_sweep", ALUresult, model(4'h5, a, 32'h0, 32'h0, 2'd0, 2'd0, 8'h00));
    end

    // Random ops including reserved codes.
    for (int k = 0; k < 400; k++) begin
      op  = 4'($urandom_range(0, 15));
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      c   = $urandom;
      idx = 2'($urandom);
      col = 2'($urandom);
      ld  = 8'($urandom);
      exp = model(op, a, b, c, idx, col, ld);
      drive(op, a, b, c, idx, col, ld);
      tick();
      check($sformatf("rand_op%0h", op), ALUresult, exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
